// File: rtl/regfile_seq_pkg.sv
// Shared definitions for the register-file sequencer: default sizes,
// op-code encoding and FSM state encoding.
package regfile_seq_pkg;

    localparam int DEFAULT_WIDTH  = 8;
    localparam int DEFAULT_ADDR_W = 3;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_MOV = 3'b110,
        OP_CMP = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

    // CMP only sets flags; every other op writes its result back.
    function automatic logic op_writes_back(input op_e op);
        return (op != OP_CMP);
    endfunction

endpackage

// File: rtl/seq_alu.sv
// Purely combinational ALU: operands and op code in, result plus zero and
// carry/borrow flags out. Arithmetic is done one bit wider so the extra
// bit carries the carry-out (ADD) or borrow (SUB/CMP).
module seq_alu
    import regfile_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  op_e              op_i,
    output logic [WIDTH-1:0] result_o,
    output logic             z_o,
    output logic             c_o
);

    logic [WIDTH:0] sum_w;
    logic [WIDTH:0] diff_w;

    assign sum_w  = {1'b0, a_i} + {1'b0, b_i};
    // Top bit of the widened difference is set exactly when a_i < b_i.
    assign diff_w = {1'b0, a_i} - {1'b0, b_i};

    // Select result and carry per op; zero flag derives from the result.
    always_comb begin
        result_o = '0;
        c_o      = 1'b0;
        unique case (op_i)
            OP_ADD: begin
                result_o = sum_w[WIDTH-1:0];
                c_o      = sum_w[WIDTH];
            end
            OP_SUB, OP_CMP: begin
                result_o = diff_w[WIDTH-1:0];
                c_o      = diff_w[WIDTH];
            end
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_NOT:  result_o = ~a_i;
            OP_MOV:  result_o = a_i;
            default: result_o = '0;
        endcase
        z_o = (result_o == '0);
    end

endmodule

// File: rtl/regfile_sequencer.sv
// Four-phase sequencer driving an external register file: accept a request
// in IDLE, read operands in READ, compute in EXEC, write back in WRITE.
// One request every four cycles; the write of one request always lands
// before the READ of the next, so read-after-write needs no forwarding.
module regfile_sequencer
    import regfile_seq_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic [2:0]        REQ_OP,
    input  logic [ADDR_W-1:0] REQ_SA,
    input  logic [ADDR_W-1:0] REQ_SB,
    input  logic [ADDR_W-1:0] REQ_DR,
    output logic [ADDR_W-1:0] SA,
    output logic [ADDR_W-1:0] SB,
    input  logic [WIDTH-1:0]  DataA,
    input  logic [WIDTH-1:0]  DataB,
    output logic [ADDR_W-1:0] DR,
    output logic [WIDTH-1:0]  D_IN,
    output logic              LD,
    output logic              DONE,
    output logic [WIDTH-1:0]  RESULT,
    output logic              FLAG_Z,
    output logic              FLAG_C
);

    state_e            state_q, state_d;
    op_e               op_q;
    logic [ADDR_W-1:0] sa_q, sb_q, dr_q;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [WIDTH-1:0]  result_q;
    logic              z_q, c_q;

    logic              accept;
    logic [WIDTH-1:0]  alu_result;
    logic              alu_z, alu_c;

    assign accept = REQ_VALID && (state_q == ST_IDLE);

    seq_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a_i      (a_q),
        .b_i      (b_q),
        .op_i     (op_q),
        .result_o (alu_result),
        .z_o      (alu_z),
        .c_o      (alu_c)
    );

    // State register; reset anywhere in the sequence abandons the request.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake/strobe outputs; strictly linear cycle.
    always_comb begin
        state_d   = state_q;
        REQ_READY = 1'b0;
        DONE      = 1'b0;
        LD        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                REQ_READY = 1'b1;
                if (accept) begin
                    state_d = ST_READ;
                end
            end
            ST_READ:  state_d = ST_EXEC;
            ST_EXEC:  state_d = ST_WRITE;
            ST_WRITE: begin
                DONE    = 1'b1;
                LD      = op_writes_back(op_q);
                state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath: latch request on acceptance, capture operands at end of
    // READ, register ALU outputs at end of EXEC. Everything else holds.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            op_q     <= OP_ADD;
            sa_q     <= '0;
            sb_q     <= '0;
            dr_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= op_e'(REQ_OP);
                sa_q <= REQ_SA;
                sb_q <= REQ_SB;
                dr_q <= REQ_DR;
            end
            if (state_q == ST_READ) begin
                a_q <= DataA;
                b_q <= DataB;
            end
            if (state_q == ST_EXEC) begin
                result_q <= alu_result;
                z_q      <= alu_z;
                c_q      <= alu_c;
            end
        end
    end

    assign SA     = sa_q;
    assign SB     = sb_q;
    assign DR     = dr_q;
    assign D_IN   = result_q;
    assign RESULT = result_q;
    assign FLAG_Z = z_q;
    assign FLAG_C = c_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench: sequencer paired with a simple register file; directed cases for
// reset, carry, compare, read-after-write, mid-op reset and input hold,
// followed by random ops checked against an array-based reference model.
module tb_regfile_sequencer;

    localparam int WIDTH  = 8;
    localparam int ADDR_W = 3;
    localparam int NREG   = 1 << ADDR_W;

    logic              CLK = 1'b0;
    logic              RESET_N;
    logic              REQ_VALID;
    logic              REQ_READY;
    logic [2:0]        REQ_OP;
    logic [ADDR_W-1:0] REQ_SA, REQ_SB, REQ_DR;
    logic [ADDR_W-1:0] SA, SB, DR;
    logic [WIDTH-1:0]  DataA, DataB, D_IN, RESULT;
    logic              LD, DONE, FLAG_Z, FLAG_C;

    // Register file companion plus a bench-side preload port.
    logic [WIDTH-1:0]  rf [NREG];
    logic              tb_we;
    logic [ADDR_W-1:0] tb_wa;
    logic [WIDTH-1:0]  tb_wd;

    int unsigned mdl [NREG];
    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    assign DataA = rf[SA];
    assign DataB = rf[SB];

    always @(posedge CLK) begin
        if (LD) rf[DR] <= D_IN;
        else if (tb_we) rf[tb_wa] <= tb_wd;
    end

    regfile_sequencer #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .REQ_OP    (REQ_OP),
        .REQ_SA    (REQ_SA),
        .REQ_SB    (REQ_SB),
        .REQ_DR    (REQ_DR),
        .SA        (SA),
        .SB        (SB),
        .DataA     (DataA),
        .DataB     (DataB),
        .DR        (DR),
        .D_IN      (D_IN),
        .LD        (LD),
        .DONE      (DONE),
        .RESULT    (RESULT),
        .FLAG_Z    (FLAG_Z),
        .FLAG_C    (FLAG_C)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour written directly from the op table with integers.
    task automatic model_op(input int op, input int unsigned a, input int unsigned b,
                            output int unsigned res, output bit z, output bit c);
        int unsigned full;
        full = 0;
        c    = 1'b0;
        case (op)
            0: begin full = a + b; c = (full > 255); end
            1, 7: begin full = a - b; c = (a < b); end
            2: full = a & b;
            3: full = a | b;
            4: full = a ^ b;
            5: full = ~a;
            6: full = a;
            default: full = 0;
        endcase
        res = full % 256;
        z   = (res == 0);
    endtask

    task automatic poke(input int addr, input int unsigned data);
        tb_we = 1'b1;
        tb_wa = ADDR_W'(addr);
        tb_wd = WIDTH'(data);
        @(posedge CLK);
        @(negedge CLK);
        tb_we = 1'b0;
        mdl[addr] = data % 256;
    endtask

    task automatic scramble();
        REQ_VALID = 1'b1;
        REQ_OP = 3'($urandom);
        REQ_SA = ADDR_W'($urandom);
        REQ_SB = ADDR_W'($urandom);
        REQ_DR = ADDR_W'($urandom);
    endtask

    // Runs one request starting at a negedge in IDLE; returns at the
    // negedge of the following IDLE cycle so calls can chain back to back.
    task automatic do_op(input int op, input int sa, input int sb, input int dr, input bit hold);
        int unsigned ea, eb, er;
        bit ez, ec, wb;
        ea = mdl[sa];
        eb = mdl[sb];
        model_op(op, ea, eb, er, ez, ec);
        wb = (op != 7);
        REQ_VALID = 1'b1;
        REQ_OP = 3'(op);
        REQ_SA = ADDR_W'(sa);
        REQ_SB = ADDR_W'(sb);
        REQ_DR = ADDR_W'(dr);
        check_val("ready_idle", REQ_READY, 1);
        @(posedge CLK); @(negedge CLK);
        if (hold) scramble(); else REQ_VALID = 1'b0;
        check_val("ready_read", REQ_READY, 0);
        check_val("sa_read", SA, sa);
        check_val("sb_read", SB, sb);
        check_val("ld_read", LD, 0);
        @(posedge CLK); @(negedge CLK);
        if (hold) scramble();
        check_val("ready_exec", REQ_READY, 0);
        check_val("ld_exec", LD, 0);
        check_val("done_exec", DONE, 0);
        @(posedge CLK); @(negedge CLK);
        REQ_VALID = 1'b0;
        check_val("done_write", DONE, 1);
        check_val("ld_write", LD, wb);
        if (wb) begin
            check_val("dr_write", DR, dr);
            check_val("din_write", D_IN, er);
        end
        check_val("result", RESULT, er);
        check_val("flag_z", FLAG_Z, ez);
        check_val("flag_c", FLAG_C, ec);
        check_val("sa_write", SA, sa);
        @(posedge CLK);
        if (wb) mdl[dr] = er;
        @(negedge CLK);
        check_val("done_idle", DONE, 0);
        check_val("ld_idle", LD, 0);
        check_val("result_held", RESULT, er);
        if (wb) check_val("rf_dest", rf[dr], er);
        $display("op=%0d sa=%0d sb=%0d dr=%0d hold=%0d a=%02h b=%02h -> res=%02h z=%0d c=%0d",
                 op, sa, sb, dr, hold, ea, eb, er, ez, ec);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET_N = 1'b0;
        REQ_VALID = 1'b0;
        REQ_OP = '0; REQ_SA = '0; REQ_SB = '0; REQ_DR = '0;
        tb_we = 1'b0; tb_wa = '0; tb_wd = '0;

        // Reset held for two edges, checked in the first cycle after release.
        @(negedge CLK); @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        check_val("rst_ready", REQ_READY, 1);
        check_val("rst_ld", LD, 0);
        check_val("rst_done", DONE, 0);
        check_val("rst_sa", SA, 0);
        check_val("rst_sb", SB, 0);
        check_val("rst_dr", DR, 0);
        check_val("rst_din", D_IN, 0);
        check_val("rst_result", RESULT, 0);
        check_val("rst_z", FLAG_Z, 0);
        check_val("rst_c", FLAG_C, 0);

        for (int i = 0; i < NREG; i++) poke(i, $urandom_range(255, 0));

        // ADD with carry out.
        poke(1, 'hF0); poke(2, 'h20);
        do_op(0, 1, 2, 3, 0);
        check_val("add_r3", rf[3], 'h10);

        // CMP of equal values: flags only, no write.
        poke(4, 'h05); poke(5, 'h05);
        do_op(7, 4, 5, 4, 0);
        check_val("cmp_r4", rf[4], 'h05);

        // Read-after-write back to back, second request with held/scrambled inputs.
        poke(1, 'h5A);
        do_op(6, 1, 0, 6, 0);
        do_op(4, 6, 6, 7, 1);
        check_val("raw_r7", rf[7], 'h00);
        check_val("raw_r6", rf[6], 'h5A);

        // Reset during EXEC aborts the write.
        REQ_VALID = 1'b1; REQ_OP = 3'd0; REQ_SA = 3'd1; REQ_SB = 3'd1; REQ_DR = 3'd2;
        @(posedge CLK); @(negedge CLK);
        REQ_VALID = 1'b0;
        @(posedge CLK); @(negedge CLK);
        RESET_N = 1'b0;
        @(posedge CLK); @(negedge CLK);
        check_val("abort_ld", LD, 0);
        check_val("abort_done", DONE, 0);
        RESET_N = 1'b1;
        @(posedge CLK); @(negedge CLK);
        check_val("abort_ready", REQ_READY, 1);
        check_val("abort_ld2", LD, 0);
        @(posedge CLK); @(negedge CLK);
        check_val("abort_ld3", LD, 0);
        check_val("abort_r2", rf[2], mdl[2]);
        $display("abort: reset in EXEC, r2=%02h", rf[2]);

        // Random ops against the model.
        for (int i = 0; i < 40; i++) begin
            do_op($urandom_range(7, 0), $urandom_range(NREG - 1, 0),
                  $urandom_range(NREG - 1, 0), $urandom_range(NREG - 1, 0),
                  1'($urandom));
        end

        for (int i = 0; i < NREG; i++) check_val("rf_final", rf[i], mdl[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_sequencer.md
REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

Interface
REQ-001 Parameter WIDTH, 8, data width of register-file entries and results.
REQ-002 Parameter ADDR_W, 3, register address width (2**ADDR_W entries).
REQ-003 CLK  input  1  sole clock, all state updates on rising edge.
REQ-004 RESET_N  input  1  synchronous, active-low reset, sampled on rising CLK.
REQ-005 REQ_VALID  input  1  request present.
REQ-006 REQ_READY  output  1  sequencer accepts request this cycle.
REQ-007 REQ_OP  input  3  operation code (see REQ-014).
REQ-008 REQ_SA, REQ_SB, REQ_DR  input  ADDR_W each  source A, source B, destination register.
REQ-009 SA, SB  output  ADDR_W each  register-file read selects.
REQ-010 DataA, DataB  input  WIDTH each  register-file read data, combinational from SA/SB.
REQ-011 DR  output  ADDR_W; D_IN  output  WIDTH; LD  output  1  register-file write port, write on CLK edge when LD=1.
REQ-012 DONE  output  1  one-cycle completion pulse; RESULT  output  WIDTH; FLAG_Z, FLAG_C  output  1 each.

Function
REQ-013 FSM states IDLE, READ, EXEC, WRITE; IDLE->READ on REQ_VALID&&REQ_READY; READ->EXEC; EXEC->WRITE; WRITE->IDLE; no other transitions.
REQ-014 Ops: 000 ADD, 001 SUB (A-B), 010 AND, 011 OR, 100 XOR, 101 NOT A, 110 MOV A, 111 CMP (SUB without writeback).
REQ-015 REQ_READY=1 only in IDLE; op, SA, SB, DR latched into internal registers on acceptance; request inputs ignored otherwise.
REQ-016 READ: SA/SB driven from latched addresses; DataA/DataB captured into operand registers at end of READ.
REQ-017 SA/SB hold latched values from READ through WRITE; in IDLE hold last value (0 after reset).
REQ-018 EXEC: result and flags computed from captured operands, registered at end of EXEC.
REQ-019 Arithmetic: ADD computed WIDTH+1 bits, FLAG_C=carry-out; SUB/CMP FLAG_C=borrow (A<B unsigned); logic/NOT/MOV FLAG_C=0; FLAG_Z=(result==0); results truncated to WIDTH.
REQ-020 WRITE: LD=1 for exactly one cycle, DR=latched DR, D_IN=result, except CMP where LD=0.
REQ-021 DONE=1 exactly in WRITE cycle for every op including CMP; RESULT/FLAG_Z/FLAG_C valid from WRITE and held until next EXEC completes.
REQ-022 Latency: acceptance cycle to write cycle = 3 cycles; throughput one request per 4 cycles; back-to-back request accepted in cycle after WRITE.
REQ-023 Read-after-write: op reading register written by previous op sees new value (write completes before next READ).
REQ-024 SA==SB and DR equal to a source are legal; no special handling.
REQ-025 LD never asserted outside WRITE; no X on any output after reset.

Reset
REQ-026 RESET_N=0 at a rising edge forces IDLE; LD=0, DONE=0, SA=SB=DR=0, D_IN=0, RESULT=0, FLAG_Z=0, FLAG_C=0, REQ_READY=1 in first cycle after reset released.
REQ-027 Reset mid-operation (READ/EXEC/WRITE) aborts request; no register-file write occurs in or after the reset cycle for that request.

Structure
REQ-028 Shared package regfile_seq_pkg holds op-code constants, FSM state encoding, default WIDTH/ADDR_W.
REQ-029 Combinational sub-module seq_alu (operands, op -> result, Z, C); sequencer holds FSM and all registers.
REQ-030 Bench instantiates sequencer with the team register file as DUT pair.

Verification
REQ-031 Reset: RESET_N=0 two cycles, then 1 -> REQ_READY=1, LD=0, DONE=0, all outputs 0.
REQ-032 ADD: R1=0xF0, R2=0x20, op ADD SA=1 SB=2 DR=3 -> 3 cycles later LD=1, DR=3, D_IN=0x10, FLAG_C=1, FLAG_Z=0, DONE=1; R3 reads 0x10.
REQ-033 CMP: R4=0x05, R5=0x05, op CMP -> DONE=1, LD=0, FLAG_Z=1, FLAG_C=0; R-file unchanged.
REQ-034 RAW back-to-back: MOV R1->R6 (R1=0x5A), then XOR SA=6 SB=6 DR=7 held valid -> second accepted cycle after first WRITE; R7=0x00, FLAG_Z=1.
REQ-035 Reset mid-op: accept ADD DR=2, drop RESET_N in EXEC -> no LD pulse, R2 unchanged, REQ_READY=1 after release.
REQ-036 Input hold: change REQ_* fields during READ/EXEC with REQ_VALID=1 -> REQ_READY=0, operation uses originally latched values.
